// File: rtl/rv_ssc_bundler_pkg.sv
// rtl/rv_ssc_bundler_pkg.sv - shared lane-flag indices, hazard field ranges and skid-buffer states
package rv_ssc_bundler_pkg;

    localparam int SSC_L1_W2 = 0;
    localparam int SSC_L1_W3 = 1;
    localparam int SSC_L2    = 2;
    localparam int SSC_L3    = 3;

    localparam int RD_LO  = 7;
    localparam int RD_HI  = 11;
    localparam int RS1_LO = 15;
    localparam int RS1_HI = 19;
    localparam int RS2_LO = 20;
    localparam int RS2_HI = 24;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ssc_regs_t;

endpackage

// File: rtl/rv_ssc_bundler_if.sv
// rtl/rv_ssc_bundler_if.sv - fetch-side and issue-side signals of the bundler
interface rv_ssc_bundler_if #(parameter int ADDR_W = 48);
    logic [2:0]        inValid;
    logic [31:0]       inWordA;
    logic [31:0]       inWordB;
    logic [31:0]       inWordC;
    logic [3:0]        inFlagA;
    logic [3:0]        inFlagB;
    logic [3:0]        inFlagC;
    logic [ADDR_W-1:0] inPc;
    logic [1:0]        inAdv;
    logic              outValid;
    logic              outReady;
    logic [31:0]       outWordA;
    logic [31:0]       outWordB;
    logic [31:0]       outWordC;
    logic [1:0]        outWidth;
    logic [ADDR_W-1:0] outPc;

    modport master (
        output inValid, inWordA, inWordB, inWordC, inFlagA, inFlagB, inFlagC, inPc,
        input  inAdv,
        input  outValid, outWordA, outWordB, outWordC, outWidth, outPc,
        output outReady
    );

    modport slave (
        input  inValid, inWordA, inWordB, inWordC, inFlagA, inFlagB, inFlagC, inPc,
        output inAdv,
        output outValid, outWordA, outWordB, outWordC, outWidth, outPc,
        input  outReady
    );
endinterface

// File: rtl/rv_ssc_hazard.sv
// rtl/rv_ssc_hazard.sv - conservative register hazard: X.rd against Y.rs1/rs2/rd
module rv_ssc_hazard
    import rv_ssc_bundler_pkg::*;
(
    input  logic [4:0] x_rd,
    input  ssc_regs_t  y,
    output logic       hz
);
    assign hz = (x_rd == y.rs1) || (x_rd == y.rs2) || (x_rd == y.rd);
endmodule

// File: rtl/rv_ssc_bundler.sv
// rtl/rv_ssc_bundler.sv - groups 1..3 instruction words into issue bundles behind a 2-entry skid buffer
module rv_ssc_bundler
    import rv_ssc_bundler_pkg::*;
#(
    parameter int ADDR_W  = 48,
    parameter bit WIDE_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    rv_ssc_bundler_if.slave bus,
    output logic [31:0] statW1,
    output logic [31:0] statW2,
    output logic [31:0] statW3
);
    typedef enum logic [1:0] {HEAD_HOLD, HEAD_NEW, HEAD_TAIL, HEAD_CLEAR} head_op_t;

    logic [4:0]  a_rd;
    ssc_regs_t   regs_b, regs_c;
    logic        hz_ab, hz_ac, hz_bc;
    logic [1:0]  width;
    logic        acc, push, pop;
    skid_state_t state, state_nxt;
    head_op_t    head_op;
    logic        tail_load, tail_clear;
    logic [31:0] new_b, new_c;
    logic [31:0] head_a, head_b, head_c, tail_a, tail_b, tail_c;
    logic [1:0]  head_w, tail_w;
    logic [ADDR_W-1:0] head_pc, tail_pc;
    logic        unused_bits;

    assign a_rd   = bus.inWordA[RD_HI:RD_LO];
    assign regs_b = '{rd: bus.inWordB[RD_HI:RD_LO], rs1: bus.inWordB[RS1_HI:RS1_LO], rs2: bus.inWordB[RS2_HI:RS2_LO]};
    assign regs_c = '{rd: bus.inWordC[RD_HI:RD_LO], rs1: bus.inWordC[RS1_HI:RS1_LO], rs2: bus.inWordC[RS2_HI:RS2_LO]};
    assign unused_bits = ^{bus.inFlagA[3:2], bus.inFlagB[3], bus.inFlagB[1:0], bus.inFlagC[2:0], regs_c.rd};

    rv_ssc_hazard u_hz_ab (.x_rd(a_rd),      .y(regs_b), .hz(hz_ab));
    rv_ssc_hazard u_hz_ac (.x_rd(a_rd),      .y(regs_c), .hz(hz_ac));
    rv_ssc_hazard u_hz_bc (.x_rd(regs_b.rd), .y(regs_c), .hz(hz_bc));

    always_comb begin
        width = 2'd0;
        if (WIDE_EN && bus.inValid == 3'b111 && bus.inFlagA[SSC_L1_W3] && bus.inFlagA[SSC_L1_W2]
            && bus.inFlagB[SSC_L2] && bus.inFlagC[SSC_L3] && !hz_ab && !hz_ac && !hz_bc)
            width = 2'd3;
        else if (WIDE_EN && bus.inValid[1] && bus.inFlagA[SSC_L1_W2] && bus.inFlagB[SSC_L2] && !hz_ab)
            width = 2'd2;
        else if (bus.inValid[0])
            width = 2'd1;
    end

    // Acceptance looks only at registered state and flush, never at outReady.
    assign acc       = (state != SKID_TWO) && !flush && !reset;
    assign bus.inAdv = acc ? width : 2'd0;
    assign push      = acc && (width != 2'd0);
    assign pop       = bus.outValid && bus.outReady;
    assign new_b     = (width >= 2'd2) ? bus.inWordB : 32'd0;
    assign new_c     = (width == 2'd3) ? bus.inWordC : 32'd0;

    always_comb begin
        state_nxt  = state;
        head_op    = HEAD_HOLD;
        tail_load  = 1'b0;
        tail_clear = 1'b0;
        case (state)
            SKID_EMPTY: if (push) begin state_nxt = SKID_ONE; head_op = HEAD_NEW; end
            SKID_ONE: begin
                if (push && !pop)      begin state_nxt = SKID_TWO; tail_load = 1'b1; end
                else if (push && pop)  head_op = HEAD_NEW;
                else if (pop)          begin state_nxt = SKID_EMPTY; head_op = HEAD_CLEAR; end
            end
            SKID_TWO: if (pop) begin state_nxt = SKID_ONE; head_op = HEAD_TAIL; tail_clear = 1'b1; end
            default: begin state_nxt = SKID_EMPTY; head_op = HEAD_CLEAR; tail_clear = 1'b1; end
        endcase
        if (flush) begin
            state_nxt  = SKID_EMPTY;
            head_op    = HEAD_CLEAR;
            tail_clear = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= SKID_EMPTY;
        else       state <= state_nxt;
    end

    // Emptied entries are zeroed so the head registers drive the outputs directly.
    always_ff @(posedge clock) begin
        if (reset) begin
            {head_a, head_b, head_c, head_w, head_pc} <= '0;
            {tail_a, tail_b, tail_c, tail_w, tail_pc} <= '0;
        end else begin
            case (head_op)
                HEAD_NEW:   {head_a, head_b, head_c, head_w, head_pc} <= {bus.inWordA, new_b, new_c, width, bus.inPc};
                HEAD_TAIL:  {head_a, head_b, head_c, head_w, head_pc} <= {tail_a, tail_b, tail_c, tail_w, tail_pc};
                HEAD_CLEAR: {head_a, head_b, head_c, head_w, head_pc} <= '0;
                default:    ;
            endcase
            if (tail_clear)
                {tail_a, tail_b, tail_c, tail_w, tail_pc} <= '0;
            else if (tail_load)
                {tail_a, tail_b, tail_c, tail_w, tail_pc} <= {bus.inWordA, new_b, new_c, width, bus.inPc};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            statW1 <= 32'd0;
            statW2 <= 32'd0;
            statW3 <= 32'd0;
        end else if (pop) begin
            case (head_w)
                2'd1:    statW1 <= statW1 + 32'd1;
                2'd2:    statW2 <= statW2 + 32'd1;
                2'd3:    statW3 <= statW3 + 32'd1;
                default: ;
            endcase
        end
    end

    assign bus.outValid = (state != SKID_EMPTY);
    assign bus.outWordA = head_a;
    assign bus.outWordB = head_b;
    assign bus.outWordC = head_c;
    assign bus.outWidth = head_w;
    assign bus.outPc    = head_pc;
endmodule

// File: tb/tb_rv_ssc_bundler.sv
// tb/tb_rv_ssc_bundler.sv - directed and random checks of rv_ssc_bundler against a bundle-list model
module tb_rv_ssc_bundler;
    localparam int ADDR_W = 48;

    logic clock = 1'b0;
    logic reset, flush;
    logic [2:0]  s_valid;
    logic [31:0] s_wa, s_wb, s_wc;
    logic [3:0]  s_fa, s_fb, s_fc;
    logic [ADDR_W-1:0] s_pc;
    logic s_ready;
    logic [31:0] w0_s1, w0_s2, w0_s3, w1_s1, w1_s2, w1_s3;

    always #5 clock = ~clock;

    rv_ssc_bundler_if #(.ADDR_W(ADDR_W)) bus0();
    rv_ssc_bundler_if #(.ADDR_W(ADDR_W)) bus1();

    assign bus0.inValid = s_valid;  assign bus1.inValid = s_valid;
    assign bus0.inWordA = s_wa;     assign bus1.inWordA = s_wa;
    assign bus0.inWordB = s_wb;     assign bus1.inWordB = s_wb;
    assign bus0.inWordC = s_wc;     assign bus1.inWordC = s_wc;
    assign bus0.inFlagA = s_fa;     assign bus1.inFlagA = s_fa;
    assign bus0.inFlagB = s_fb;     assign bus1.inFlagB = s_fb;
    assign bus0.inFlagC = s_fc;     assign bus1.inFlagC = s_fc;
    assign bus0.inPc    = s_pc;     assign bus1.inPc    = s_pc;
    assign bus0.outReady = s_ready; assign bus1.outReady = s_ready;

    rv_ssc_bundler #(.ADDR_W(ADDR_W), .WIDE_EN(1'b0)) u_scalar (
        .clock(clock), .reset(reset), .flush(flush), .bus(bus0.slave),
        .statW1(w0_s1), .statW2(w0_s2), .statW3(w0_s3));
    rv_ssc_bundler #(.ADDR_W(ADDR_W), .WIDE_EN(1'b1)) u_wide (
        .clock(clock), .reset(reset), .flush(flush), .bus(bus1.slave),
        .statW1(w1_s1), .statW2(w1_s2), .statW3(w1_s3));

    typedef struct {
        logic [31:0] a, b, c;
        logic [1:0]  width;
        logic [ADDR_W-1:0] pc;
    } bundle_t;

    bundle_t     mq[2][2];
    int          mcnt[2];
    logic [31:0] mstat[2][3];
    logic [1:0]  madv[2];
    int total = 0;
    int bad = 0;

    function automatic bit hz(input logic [31:0] x, input logic [31:0] y);
        return (x[11:7] == y[19:15]) || (x[11:7] == y[24:20]) || (x[11:7] == y[11:7]);
    endfunction

    function automatic logic [1:0] exp_width(input bit wide);
        if (wide && s_valid == 3'b111 && s_fa[1:0] == 2'b11 && s_fb[2] && s_fc[3]
            && !hz(s_wa, s_wb) && !hz(s_wa, s_wc) && !hz(s_wb, s_wc)) return 2'd3;
        if (wide && s_valid[1] && s_fa[0] && s_fb[2] && !hz(s_wa, s_wb)) return 2'd2;
        if (s_valid[0]) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input int k);
        bundle_t nb;
        bit do_pop;
        nb.a = s_wa;
        nb.b = (madv[k] >= 2'd2) ? s_wb : 32'd0;
        nb.c = (madv[k] == 2'd3) ? s_wc : 32'd0;
        nb.width = madv[k];
        nb.pc = s_pc;
        do_pop = (mcnt[k] > 0) && s_ready;
        if (reset) begin
            mcnt[k] = 0;
            for (int i = 0; i < 3; i++) mstat[k][i] = 32'd0;
        end else begin
            if (do_pop) mstat[k][int'(mq[k][0].width) - 1] += 32'd1;
            if (flush) mcnt[k] = 0;
            else begin
                if (do_pop) begin
                    mq[k][0] = mq[k][1];
                    mcnt[k]--;
                end
                if (madv[k] != 2'd0) begin
                    mq[k][mcnt[k]] = nb;
                    mcnt[k]++;
                end
            end
        end
    endtask

    task automatic check_outs(input int k);
        bundle_t h;
        logic ov;
        logic [1:0] ow;
        logic [31:0] oa, ob, oc, s1, s2, s3;
        logic [ADDR_W-1:0] opc;
        h = '{a: 32'd0, b: 32'd0, c: 32'd0, width: 2'd0, pc: '0};
        if (mcnt[k] > 0) h = mq[k][0];
        if (k == 0) begin
            ov = bus0.outValid; ow = bus0.outWidth; oa = bus0.outWordA; ob = bus0.outWordB;
            oc = bus0.outWordC; opc = bus0.outPc; s1 = w0_s1; s2 = w0_s2; s3 = w0_s3;
        end else begin
            ov = bus1.outValid; ow = bus1.outWidth; oa = bus1.outWordA; ob = bus1.outWordB;
            oc = bus1.outWordC; opc = bus1.outPc; s1 = w1_s1; s2 = w1_s2; s3 = w1_s3;
        end
        check($sformatf("u%0d_valid", k), 64'(ov), 64'(mcnt[k] > 0));
        check($sformatf("u%0d_width", k), 64'(ow), 64'(h.width));
        check($sformatf("u%0d_word_a", k), 64'(oa), 64'(h.a));
        check($sformatf("u%0d_word_b", k), 64'(ob), 64'(h.b));
        check($sformatf("u%0d_word_c", k), 64'(oc), 64'(h.c));
        check($sformatf("u%0d_pc", k), 64'(opc), 64'(h.pc));
        check($sformatf("u%0d_stat_w1", k), 64'(s1), 64'(mstat[k][0]));
        check($sformatf("u%0d_stat_w2", k), 64'(s2), 64'(mstat[k][1]));
        check($sformatf("u%0d_stat_w3", k), 64'(s3), 64'(mstat[k][2]));
    endtask

    task automatic cycle();
        #1;
        for (int k = 0; k < 2; k++)
            madv[k] = (!reset && !flush && mcnt[k] < 2) ? exp_width(k == 1) : 2'd0;
        check("u0_adv", 64'(bus0.inAdv), 64'(madv[0]));
        check("u1_adv", 64'(bus1.inAdv), 64'(madv[1]));
        @(posedge clock);
        for (int k = 0; k < 2; k++) model_update(k);
        @(negedge clock);
        for (int k = 0; k < 2; k++) check_outs(k);
    endtask

    initial begin
        logic [31:0] stat_before;
        reset = 1'b1; flush = 1'b0; s_ready = 1'b1; s_valid = 3'b000;
        s_wa = 32'd0; s_wb = 32'd0; s_wc = 32'd0;
        s_fa = 4'h0; s_fb = 4'h0; s_fc = 4'h0; s_pc = '0;
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            for (int i = 0; i < 3; i++) mstat[k][i] = 32'd0;
        end
        cycle();
        cycle();
        reset = 1'b0;

        // three independent words, all lanes permitted
        s_wa = 32'h00510093; s_wb = 32'h00220193; s_wc = 32'h00430293;
        s_fa = 4'hF; s_fb = 4'hF; s_fc = 4'hF; s_valid = 3'b111; s_pc = 48'h0000_8000_1000;
        cycle();
        check("w3_width", 64'(bus1.outWidth), 64'd3);
        check("w3_pc", 64'(bus1.outPc), 64'h0000_8000_1000);
        check("scalar_width", 64'(bus0.outWidth), 64'd1);
        s_valid = 3'b000;
        cycle();
        check("w3_stat", 64'(w1_s3), 64'd1);

        // RAW on x1 between A and B
        s_wa = 32'h00510093; s_wb = 32'h00108193; s_valid = 3'b011; s_pc = 48'h0000_8000_2000;
        cycle();
        check("raw_width", 64'(bus1.outWidth), 64'd1);
        s_wa = 32'h00108193; s_valid = 3'b001; s_pc = 48'h0000_8000_2004;
        cycle();
        check("raw_b_issues", 64'(bus1.outWordA), 64'h00108193);
        s_valid = 3'b000;
        cycle();

        // A may only pair, not triple
        s_wa = 32'h00510093; s_wb = 32'h00220193; s_wc = 32'h00430293;
        s_fa = 4'h1; s_fb = 4'hF; s_fc = 4'hF; s_valid = 3'b111; s_pc = 48'h0000_8000_3000;
        cycle();
        check("pair_width", 64'(bus1.outWidth), 64'd2);
        check("pair_word_c", 64'(bus1.outWordC), 64'd0);
        s_valid = 3'b000;
        cycle();

        // backpressure fills the skid buffer
        s_ready = 1'b0; s_valid = 3'b001; s_fa = 4'h0;
        for (int i = 0; i < 3; i++) begin
            s_wa = rand_word(); s_pc = 48'h0000_8000_4000 + 48'(4 * i);
            cycle();
        end
        check("bp_full_adv", 64'(bus1.inAdv), 64'd0);
        s_ready = 1'b1;
        cycle();
        check("bp_resume_adv", 64'(bus1.inAdv), 64'd1);
        for (int i = 0; i < 3; i++) begin
            s_wa = rand_word(); s_pc = s_pc + 48'd4;
            cycle();
        end

        // flush while full, head accepted in the same cycle
        s_valid = 3'b000;
        cycle(); cycle();
        s_ready = 1'b0; s_valid = 3'b001;
        cycle(); cycle();
        stat_before = mstat[1][0];
        s_ready = 1'b1; flush = 1'b1;
        cycle();
        check("flush_valid", 64'(bus1.outValid), 64'd0);
        check("flush_stat", 64'(w1_s1), 64'(stat_before + 32'd1));
        flush = 1'b0;

        // reset while full
        s_ready = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
        cycle();
        check("rst_valid", 64'(bus1.outValid), 64'd0);
        check("rst_stat1", 64'(w1_s1), 64'd0);
        check("rst_stat3", 64'(w1_s3), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: s_valid = 3'b000;
                1: s_valid = 3'b001;
                2: s_valid = 3'b011;
                default: s_valid = 3'b111;
            endcase
            s_wa = rand_word(); s_wb = rand_word(); s_wc = rand_word();
            s_fa = 4'($urandom); s_fb = 4'($urandom); s_fc = 4'($urandom);
            s_pc = {16'h0, 32'($urandom)};
            s_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
